wb_frame_fetch: RTL and testbench
=================================

WB_FRAME_FETCH -- requirements
Module: wb_frame_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: output FIFO depth in 32-bit words; power of two, 2..64.
REQ-002 Parameter LEN_WIDTH, default 16: width of word_count.
REQ-003 Parameter TIMEOUT, default 255: ack-wait limit in clk cycles, used only with the timeout feature.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a fetch; sampled only in IDLE.
REQ-007 base_adr  in  32  byte address of the first word; bits [1:0] ignored and treated as 0.
REQ-008 word_count  in  LEN_WIDTH  number of 32-bit words to fetch.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when the fetch finishes or aborts.
REQ-011 error  out  1  sticky abort flag; cleared by the next accepted start.
REQ-012 wb_cyc_o, wb_stb_o  out  1 each  Wishbone master cycle and strobe.
REQ-013 wb_we_o  out  1  constant 0; the block only reads.
REQ-014 wb_adr_o  out  32  Wishbone byte address.
REQ-015 wb_sel_o  out  4  constant 4'b1111.
REQ-016 wb_dat_i  in  32  read data.  wb_ack_i  in  1  transfer acknowledge.
REQ-017 out_valid  out  1, out_data  out  32, out_ready  in  1  output stream; a word transfers when out_valid and out_ready are both high.

Function
REQ-018 FSM states: IDLE, REQ, ACKW, DONE.
REQ-019 IDLE: on start, latch base_adr and word_count, clear error, and set busy. If word_count==0, go to DONE with no bus cycle. Otherwise go to REQ.
REQ-020 REQ: assert cyc and stb with the current address only if FIFO free slots >= 1; otherwise stay in REQ with cyc and stb low. On assertion go to ACKW.
REQ-021 ACKW: hold cyc, stb and adr stable until wb_ack_i is high. On the ack edge:
  - write wb_dat_i into the FIFO;
  - add 4 to the address (mod 2^32);
  - decrement the remaining count;
  - drive cyc and stb low the next cycle;
  - go to REQ, or to DONE if the remaining count reaches 0.
REQ-022 At most one transfer is outstanding. cyc and stb are low for at least one cycle between transfers.
REQ-023 DONE: pulse done for one cycle, clear busy, and return to IDLE. The FIFO contents are kept and continue to drain.
REQ-024 start while busy is ignored.
REQ-025 FIFO:
  - first word fall-through, so out_valid is high whenever the FIFO is non-empty and out_data is the head word;
  - a write and a read in the same cycle are both performed, and the count is unchanged;
  - a write when full never occurs, because REQ-020 prevents it.
REQ-026 Latency: the first acked word appears on out_valid in the cycle after the ack edge.

Reset
REQ-027 Reset values:
  - state=IDLE;
  - cyc, stb, busy, done and error = 0;
  - wb_adr_o = 0;
  - FIFO empty, so out_valid = 0.
REQ-028 Reset during a bus cycle drops cyc and stb in the next cycle, discards the outstanding transfer, and does not pulse done.

Configuration
REQ-029 Macro WB_FRAME_FETCH_TIMEOUT_EN enables the ack timeout.
REQ-030 When the macro is defined:
  - a counter counts ACKW cycles;
  - if TIMEOUT cycles pass without an ack, cyc and stb are dropped, error is set, the FIFO is kept, and the FSM goes to DONE;
  - the counter clears on every entry to ACKW.
REQ-031 When the macro is undefined, ACKW waits indefinitely, error is tied to 0, and no counter logic exists.

Structure
REQ-032 A shared package wb_fetch_pkg holds the FSM state encoding and the WB_SEL_ALL constant.
REQ-033 The FIFO is a sub-module, sync_fifo_fwft, parameterised by width and depth, with full, empty and count outputs.

Verification
REQ-034 Basic fetch:
  - stimulus: base_adr=0x100, word_count=3, slave acks one cycle after stb, out_ready=1;
  - required: addresses 0x100, 0x104, 0x108; data emitted in order; one done pulse; busy is high for the whole transfer.
REQ-035 Zero-length fetch:
  - stimulus: word_count=0;
  - required: done pulses within 2 cycles of start; cyc never rises.
REQ-036 Backpressure with FIFO_DEPTH=8:
  - stimulus: out_ready=0 and word_count=12;
  - required: exactly 8 bus transfers, then cyc stays low; after out_ready=1 the remaining 4 transfers complete and all 12 words are delivered in order.
REQ-037 Address wrap:
  - stimulus: base_adr=0xFFFFFFFC, word_count=2;
  - required: addresses 0xFFFFFFFC, then 0x00000000.
REQ-038 Timeout with the macro defined and TIMEOUT=16:
  - stimulus: the slave never acks;
  - required: cyc drops 16 cycles after stb rises; error=1; done pulses once.
  Without the macro, the same stimulus leaves cyc held high and error=0.
REQ-039 Reset mid-fetch and restart:
  - stimulus: reset asserted during ACKW of word 2 of 5;
  - required: cyc=0 and out_valid=0 after reset, no done pulse; a new start then fetches correctly.

Source files
------------

// File: rtl/wb_fetch_pkg.sv
// ---------------------------------------------------------------------------
// wb_fetch_pkg
// Shared definitions for the Wishbone frame fetcher:
//   fetch_state_t : FSM state encoding (IDLE, REQ, ACKW, DONE)
//   WB_SEL_ALL    : byte-select value for full 32-bit reads
//   WORD_BYTES    : address increment between consecutive words
// ---------------------------------------------------------------------------
package wb_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKW = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'b1111;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wb_frame_fetch_if.sv
// ---------------------------------------------------------------------------
// wb_frame_fetch_if
// Wishbone classic read-master bus bundle used by wb_frame_fetch.
//   wb_cyc_o, wb_stb_o : cycle / strobe          (master -> slave)
//   wb_we_o            : write enable, always 0  (master -> slave)
//   wb_adr_o[31:0]     : byte address            (master -> slave)
//   wb_sel_o[3:0]      : byte selects            (master -> slave)
//   wb_dat_i[31:0]     : read data               (slave -> master)
//   wb_ack_i           : transfer acknowledge    (slave -> master)
// Modports: master (the fetcher), slave (memory / bus model).
// ---------------------------------------------------------------------------
interface wb_frame_fetch_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o,
    output wb_stb_o,
    output wb_we_o,
    output wb_adr_o,
    output wb_sel_o,
    input  wb_dat_i,
    input  wb_ack_i
  );

  modport slave (
    input  wb_cyc_o,
    input  wb_stb_o,
    input  wb_we_o,
    input  wb_adr_o,
    input  wb_sel_o,
    output wb_dat_i,
    output wb_ack_i
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO.
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data : push one word (ignored when full)
//   rd_en          : pop the head word (ignored when empty)
//   rd_data        : head word, valid whenever empty is low
//   full, empty    : occupancy flags
//   count          : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// The head word is read combinationally from the storage array so it is
// visible in the cycle right after it is written; with the small depths
// used here this maps to distributed RAM.
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({wr_fire, rd_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_frame_fetch.sv
// ---------------------------------------------------------------------------
// wb_frame_fetch
// Reads word_count consecutive 32-bit words over Wishbone starting at
// base_adr and streams them out through a first-word-fall-through FIFO.
// One transfer is outstanding at a time; cyc/stb drop for at least one cycle
// after every ack. A new bus request is only issued when the FIFO has a free
// slot, so a stalled consumer throttles the bus instead of losing data.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle fetch request, honoured only when idle
//   base_adr[31:0]    : byte address of first word (bits [1:0] ignored)
//   word_count        : words to fetch (0 = finish immediately, no bus cycle)
//   busy              : fetch in progress
//   done              : one-cycle pulse on completion or abort
//   error             : sticky abort flag, cleared by the next start
//   wb                : Wishbone read master (wb_frame_fetch_if.master)
//   out_valid/out_data/out_ready : output word stream
//
// Build option: define WB_FRAME_FETCH_TIMEOUT_EN to abort a transfer whose
// ack has not arrived after TIMEOUT cycles in ACKW. Without it ACKW waits
// forever and error stays 0.
// ---------------------------------------------------------------------------
module wb_frame_fetch
  import wb_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          base_adr,
  input  logic [LEN_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  wb_frame_fetch_if.master     wb,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  input  logic                 out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fetch_state_t         state_reg;
  logic [31:0]          adr_reg;
  logic [LEN_WIDTH-1:0] remain_reg;
  logic                 cyc_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic                 fifo_wr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AW:0]          fifo_count;
  logic [AW:0]          fifo_free;
  logic                 fifo_room;
  logic                 ack_hit;

  // An ack only counts while our own transfer is outstanding.
  assign ack_hit   = (state_reg == ACKW) && wb.wb_ack_i;
  assign fifo_wr   = ack_hit && !fifo_full;
  assign fifo_free = (AW+1)'(FIFO_DEPTH) - fifo_count;
  assign fifo_room = (fifo_free != '0);

  sync_fifo_fwft #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (wb.wb_dat_i),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;

`ifdef WB_FRAME_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_reg;
  logic          error_reg;

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      adr_reg    <= '0;
      remain_reg <= '0;
      cyc_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef WB_FRAME_FETCH_TIMEOUT_EN
      to_cnt_reg <= '0;
      error_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            adr_reg    <= base_adr & ~32'h3;
            remain_reg <= word_count;
            busy_reg   <= 1'b1;
`ifdef WB_FRAME_FETCH_TIMEOUT_EN
            error_reg  <= 1'b0;
`endif
            state_reg  <= (word_count == '0) ? DONE : REQ;
          end
        end

        REQ: begin
          // Only request when the returning word is guaranteed a FIFO slot.
          if (fifo_room) begin
            cyc_reg    <= 1'b1;
            state_reg  <= ACKW;
`ifdef WB_FRAME_FETCH_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
          end
        end

        ACKW: begin
          if (wb.wb_ack_i) begin
            cyc_reg    <= 1'b0;
            adr_reg    <= adr_reg + WORD_BYTES;
            remain_reg <= remain_reg - 1'b1;
            state_reg  <= (remain_reg == LEN_WIDTH'(1)) ? DONE : REQ;
          end
`ifdef WB_FRAME_FETCH_TIMEOUT_EN
          else if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
            // Abandon the transfer; words already fetched stay in the FIFO.
            cyc_reg   <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign wb.wb_cyc_o = cyc_reg;
  assign wb.wb_stb_o = cyc_reg;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_adr_o = adr_reg;
  assign wb.wb_sel_o = WB_SEL_ALL;

endmodule

// File: tb/tb_wb_frame_fetch.sv
// ---------------------------------------------------------------------------
// tb_wb_frame_fetch
// Directed bench for wb_frame_fetch (FIFO_DEPTH=8, TIMEOUT=16). A Wishbone
// slave model acks after a programmable delay and returns data derived from
// the address; monitors log bus addresses, delivered stream words, done
// pulses and handshake violations. Timeout expectations follow
// WB_FRAME_FETCH_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_frame_fetch;

  localparam int DEPTH = 8;
  localparam int LW    = 16;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   base_adr;
  logic [LW-1:0] word_count;
  logic          busy;
  logic          done;
  logic          error;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready;

  wb_frame_fetch_if wb ();

  wb_frame_fetch #(
    .FIFO_DEPTH (DEPTH),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_adr   (base_adr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .wb         (wb),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Read data returned by the slave for a given address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // ---------------- slave model and monitors (sampled on negedge) ----------
  int          ack_delay  = 1;
  bit          slave_mute = 1'b0;
  int          wait_cnt   = 0;
  logic        prev_ack   = 1'b0;
  logic        prev_cyc   = 1'b0;
  logic [31:0] adr_q[$];
  logic [31:0] out_q[$];
  int          done_cnt   = 0;
  int          cyc_rise   = 0;
  int          gap_viol   = 0;
  int          busy_viol  = 0;

  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      // cyc must be low in the cycle after an ack.
      if (wb.wb_cyc_o && prev_ack) gap_viol++;
      if (wb.wb_cyc_o && !busy) busy_viol++;
      if (wb.wb_cyc_o && !prev_cyc) cyc_rise++;
      prev_cyc = wb.wb_cyc_o;
      if (done) done_cnt++;
      if (out_valid && out_ready) out_q.push_back(out_data);

      if (wb.wb_cyc_o && wb.wb_stb_o && !slave_mute) begin
        if (wait_cnt >= ack_delay) begin
          wb.wb_ack_i = 1'b1;
          wb.wb_dat_i = pat(wb.wb_adr_o);
          adr_q.push_back(wb.wb_adr_o);
        end else begin
          wb.wb_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        wb.wb_ack_i = 1'b0;
        wait_cnt = 0;
      end
      prev_ack = wb.wb_ack_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    adr_q.delete();
    out_q.delete();
    done_cnt  = 0;
    cyc_rise  = 0;
    gap_viol  = 0;
    busy_viol = 0;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [LW-1:0] n);
    base_adr   = a;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_words(input string tag, input logic [31:0] base, input int n);
    chk({tag, " bus xfers"}, 32'(adr_q.size()), 32'(n));
    chk({tag, " words out"}, 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [31:0] ea;
      ea = base + 32'(4 * i);
      if (i < adr_q.size()) chk($sformatf("%s adr[%0d]", tag, i), adr_q[i], ea);
      if (i < out_q.size()) chk($sformatf("%s dat[%0d]", tag, i), out_q[i], pat(ea));
    end
  endtask

  // ---------------- stimulus -----------------------------------------------
  initial begin
    int k;
    reset      = 1'b1;
    start      = 1'b0;
    base_adr   = '0;
    word_count = '0;
    out_ready  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst cyc",       32'(wb.wb_cyc_o), 32'd0);
    chk("rst stb",       32'(wb.wb_stb_o), 32'd0);
    chk("rst adr",       wb.wb_adr_o,      32'd0);
    chk("rst busy",      32'(busy),        32'd0);
    chk("rst done",      32'(done),        32'd0);
    chk("rst error",     32'(error),       32'd0);
    chk("rst out_valid", 32'(out_valid),   32'd0);
    chk("rst we",        32'(wb.wb_we_o),  32'd0);
    chk("rst sel",       32'(wb.wb_sel_o), 32'hF);

    // Basic fetch: 3 words from 0x100
    clr();
    do_start(32'h100, 3);
    chk("basic busy after start", 32'(busy), 32'd1);
    wait_done("basic", 60);
    chk("basic busy at done", 32'(busy), 32'd0);
    repeat (3) tick();
    chk_words("basic", 32'h100, 3);
    chk("basic done pulses", 32'(done_cnt),  32'd1);
    chk("basic cyc w/o busy", 32'(busy_viol), 32'd0);
    chk("basic cyc gap",      32'(gap_viol),  32'd0);

    // Zero-length fetch
    clr();
    base_adr   = 32'h200;
    word_count = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (!done && k < 5) begin
      tick();
      k++;
    end
    chk("zero done within 2", 32'(done && (k <= 2)), 32'd1);
    repeat (3) tick();
    chk("zero cyc rises",   32'(cyc_rise), 32'd0);
    chk("zero done pulses", 32'(done_cnt), 32'd1);

    // Backpressure: 12 words into an 8-deep FIFO with the consumer stalled
    clr();
    out_ready = 1'b0;
    do_start(32'h2000, 12);
    repeat (80) tick();
    chk("bp xfers while stalled", 32'(adr_q.size()), 32'd8);
    chk("bp cyc parked",          32'(wb.wb_cyc_o),  32'd0);
    chk("bp busy",                32'(busy),         32'd1);
    chk("bp out_valid",           32'(out_valid),    32'd1);
    chk("bp head word",           out_data,          pat(32'h2000));
    out_ready = 1'b1;
    wait_done("bp", 120);
    repeat (3) tick();
    chk_words("bp", 32'h2000, 12);
    chk("bp done pulses", 32'(done_cnt), 32'd1);
    chk("bp cyc gap",     32'(gap_viol), 32'd0);

    // Address wrap
    clr();
    do_start(32'hFFFF_FFFC, 2);
    wait_done("wrap", 40);
    repeat (3) tick();
    chk_words("wrap", 32'hFFFF_FFFC, 2);

    // Slave never acks
    clr();
    slave_mute = 1'b1;
    do_start(32'h300, 2);
    k = 0;
    while (!wb.wb_cyc_o && k < 10) begin
      tick();
      k++;
    end
    chk("to cyc rose", 32'(wb.wb_cyc_o), 32'd1);
    k = 0;
    while (wb.wb_cyc_o && k < 40) begin
      tick();
      k++;
    end
`ifdef WB_FRAME_FETCH_TIMEOUT_EN
    chk("to cyc high cycles", 32'(k), 32'd16);
    wait_done("to", 5);
    repeat (3) tick();
    chk("to error",       32'(error),    32'd1);
    chk("to done pulses", 32'(done_cnt), 32'd1);
    chk("to busy",        32'(busy),     32'd0);
`else
    chk("to cyc held",    32'(wb.wb_cyc_o), 32'd1);
    chk("to error",       32'(error),       32'd0);
    chk("to done pulses", 32'(done_cnt),    32'd0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
`endif
    slave_mute = 1'b0;

    // Reset during ACKW of word 2 of 5, then restart
    clr();
    out_ready = 1'b0;
    do_start(32'h400, 5);
    chk("rr error cleared by start", 32'(error), 32'd0);
    k = 0;
    while (!(adr_q.size() == 1 && wb.wb_cyc_o) && k < 40) begin
      tick();
      k++;
    end
    chk("rr reached word 2", 32'(adr_q.size() == 1 && wb.wb_cyc_o), 32'd1);
    slave_mute = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rr cyc",       32'(wb.wb_cyc_o), 32'd0);
    chk("rr out_valid", 32'(out_valid),   32'd0);
    chk("rr busy",      32'(busy),        32'd0);
    repeat (3) tick();
    chk("rr no done",   32'(done_cnt),    32'd0);

    clr();
    slave_mute = 1'b0;
    out_ready  = 1'b1;
    do_start(32'h500, 4);
    wait_done("restart", 60);
    repeat (3) tick();
    chk_words("restart", 32'h500, 4);
    chk("restart done pulses", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
